// File: rtl/bcd_overlay_scanner.sv
// ----------------------------------------------------------------------------
// bcd_overlay_scanner
//
// Front stage for bcd_seq_display_controller. Maps VGA raster coordinates
// into font-local ROM coordinates for a numeric overlay window, snapshots the
// displayed value once per frame (no mid-frame tearing), and runs a blink
// counter for FLASH_FRAMES frames after the displayed value changes.
//
// Optional feature macro: SCALE_2X_EN
//   defined   : glyphs drawn at 2x (window SEQ_DIGITS*16 x 16 px)
//   undefined : glyphs drawn at 1x (window SEQ_DIGITS*8 x 8 px)
//
// Ports:
//   clk, rst     : pixel clock, synchronous active-high reset
//   pixel_x/y    : current raster position
//   video_on     : active-video qualifier
//   frame_start  : one-cycle pulse at the start of every frame
//   seq_in       : live value to display
//   origin_x/y   : window top-left corner
//   seq_out      : frame-stable snapshot of seq_in
//   seq_x_rom    : window-local mirrored x (2-cycle latency)
//   seq_y_rom    : window-local mirrored y (2-cycle latency)
//   in_window    : pixel lies inside the window (2-cycle latency)
//   flash        : blink phase while the post-change counter runs
//
// There is no handshake on this block: every input is sampled each clock and
// every output is a registered value (or a pure decode of one).
// ----------------------------------------------------------------------------
module bcd_overlay_scanner #(
  parameter int SCREEN_WIDTH = 10,
  parameter int SEQ_LEN      = 20,
  parameter int SEQ_DIGITS   = (SEQ_LEN >> 2) + 1,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SCREEN_WIDTH-1:0] pixel_x,
  input  logic [SCREEN_WIDTH-1:0] pixel_y,
  input  logic                    video_on,
  input  logic                    frame_start,
  input  logic [SEQ_LEN-1:0]      seq_in,
  input  logic [SCREEN_WIDTH-1:0] origin_x,
  input  logic [SCREEN_WIDTH-1:0] origin_y,
  output logic [SEQ_LEN-1:0]      seq_out,
  output logic [SCREEN_WIDTH-1:0] seq_x_rom,
  output logic [SCREEN_WIDTH-1:0] seq_y_rom,
  output logic                    in_window,
  output logic                    flash
);

`ifdef SCALE_2X_EN
  localparam int SCALE_SHIFT = 1;
`else
  localparam int SCALE_SHIFT = 0;
`endif

  localparam int GLYPH_PX = 8 << SCALE_SHIFT;
  localparam int WIN_W    = SEQ_DIGITS * GLYPH_PX;
  localparam int WIN_H    = GLYPH_PX;
  localparam int CW       = SCREEN_WIDTH + 1;
  localparam int FLASH_W  = $clog2(FLASH_FRAMES + 1);

  // Font-space maxima: the mirror is done after undoing the scale.
  localparam logic [SCREEN_WIDTH-1:0] X_TOP = SCREEN_WIDTH'(SEQ_DIGITS * 8 - 1);
  localparam logic [SCREEN_WIDTH-1:0] Y_TOP = SCREEN_WIDTH'(7);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic                    hit1_q,      hit1_d;
  logic [SCREEN_WIDTH-1:0] dx1_q,       dx1_d;
  logic [SCREEN_WIDTH-1:0] dy1_q,       dy1_d;
  logic                    in_window_q, in_window_d;
  logic [SCREEN_WIDTH-1:0] x_rom_q,     x_rom_d;
  logic [SCREEN_WIDTH-1:0] y_rom_q,     y_rom_d;
  logic [SEQ_LEN-1:0]      seq_q,       seq_d;
  logic [FLASH_W-1:0]      flash_cnt_q, flash_cnt_d;

  // --------------------------------------------------------------------------
  // Stage 1: offsets and hit test. Bounds use one extra bit so a window that
  // hangs off the right/bottom screen edge does not wrap back to column 0.
  // --------------------------------------------------------------------------
  logic [CW-1:0] px_ext, py_ext, ox_ext, oy_ext, x_end, y_end;

  always_comb begin
    px_ext = {1'b0, pixel_x};
    py_ext = {1'b0, pixel_y};
    ox_ext = {1'b0, origin_x};
    oy_ext = {1'b0, origin_y};
    x_end  = ox_ext + CW'(WIN_W);
    y_end  = oy_ext + CW'(WIN_H);

    hit1_d = video_on
           & (px_ext >= ox_ext) & (px_ext < x_end)
           & (py_ext >= oy_ext) & (py_ext < y_end);
    dx1_d  = pixel_x - origin_x;
    dy1_d  = pixel_y - origin_y;
  end

  // --------------------------------------------------------------------------
  // Stage 2: mirror into ROM space. Mirroring x puts the sign glyph / MSD on
  // the left and font bit 7 at each glyph's left pixel; mirroring y puts font
  // row 7 on top. Misses force zeros so downstream never sees stale offsets.
  // --------------------------------------------------------------------------
  always_comb begin
    in_window_d = 1'b0;
    x_rom_d     = '0;
    y_rom_d     = '0;
    if (hit1_q) begin
      in_window_d = 1'b1;
      x_rom_d     = X_TOP - (dx1_q >> SCALE_SHIFT);
      y_rom_d     = Y_TOP - (dy1_q >> SCALE_SHIFT);
    end
  end

  // --------------------------------------------------------------------------
  // Value snapshot and flash counter. The change test compares against the
  // value still held in seq_q, i.e. the snapshot from the previous frame.
  // --------------------------------------------------------------------------
  always_comb begin
    seq_d       = seq_q;
    flash_cnt_d = flash_cnt_q;
    if (frame_start) begin
      seq_d = seq_in;
      if (seq_in != seq_q) begin
        flash_cnt_d = FLASH_W'(FLASH_FRAMES);
      end else if (flash_cnt_q != '0) begin
        flash_cnt_d = flash_cnt_q - FLASH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit1_q      <= 1'b0;
      dx1_q       <= '0;
      dy1_q       <= '0;
      in_window_q <= 1'b0;
      x_rom_q     <= '0;
      y_rom_q     <= '0;
      seq_q       <= '0;
      flash_cnt_q <= '0;
    end else begin
      hit1_q      <= hit1_d;
      dx1_q       <= dx1_d;
      dy1_q       <= dy1_d;
      in_window_q <= in_window_d;
      x_rom_q     <= x_rom_d;
      y_rom_q     <= y_rom_d;
      seq_q       <= seq_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign seq_out   = seq_q;
  assign seq_x_rom = x_rom_q;
  assign seq_y_rom = y_rom_q;
  assign in_window = in_window_q;

  // Blink phase: bit 2 of the frame counter gives a ~4-frame on/off cadence.
  generate
    if (FLASH_W >= 3) begin : g_flash
      assign flash = (flash_cnt_q != '0) & flash_cnt_q[2];
    end else begin : g_flash_short
      assign flash = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_bcd_overlay_scanner.sv
// ----------------------------------------------------------------------------
// tb_bcd_overlay_scanner
//
// Self-checking bench for bcd_overlay_scanner at default parameters. The
// reference model works from window geometry with plain integer arithmetic
// and tracks the displayed value / flash frame count as simple variables.
// ----------------------------------------------------------------------------
module tb_bcd_overlay_scanner;

  localparam int SW         = 10;
  localparam int SL         = 20;
  localparam int DIGITS     = (SL >> 2) + 1;
  localparam int FLASH_N    = 30;
`ifdef SCALE_2X_EN
  localparam int SC         = 2;
`else
  localparam int SC         = 1;
`endif

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] pixel_x, pixel_y, origin_x, origin_y;
  logic          video_on, frame_start;
  logic [SL-1:0] seq_in;
  logic [SL-1:0] seq_out;
  logic [SW-1:0] seq_x_rom, seq_y_rom;
  logic          in_window, flash;

  always #5 clk = ~clk;

  bcd_overlay_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .frame_start (frame_start),
    .seq_in      (seq_in),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .seq_out     (seq_out),
    .seq_x_rom   (seq_x_rom),
    .seq_y_rom   (seq_y_rom),
    .in_window   (in_window),
    .flash       (flash)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard for the coordinate pipeline: {in_window, x_rom, y_rom}
  logic [2*SW:0] exp_q[$];

  // Value / flash model
  logic [SL-1:0] m_seq;
  int            m_cnt;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [2*SW:0] pix_model(int px, int py, int ox, int oy, bit vo);
    int ww, wh, x, y;
    logic [SW-1:0] xv, yv;
    ww = DIGITS * 8 * SC;
    wh = 8 * SC;
    if (vo && px >= ox && px < ox + ww && py >= oy && py < oy + wh) begin
      x  = (DIGITS * 8 - 1) - (px - ox) / SC;
      y  = 7 - (py - oy) / SC;
      xv = SW'(x);
      yv = SW'(y);
      return {1'b1, xv, yv};
    end
    return '0;
  endfunction

  function automatic bit flash_model(int cnt);
    return (cnt != 0) && (((cnt / 4) % 2) == 1);
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(int px, int py, int ox, int oy, bit vo);
    pixel_x  = SW'(px);
    pixel_y  = SW'(py);
    origin_x = SW'(ox);
    origin_y = SW'(oy);
    video_on = vo;
  endtask

  // One frame_start pulse with the model stepped to match.
  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (seq_in != m_seq) m_cnt = FLASH_N;
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
    m_seq = seq_in;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    frame_start = 1'b1;
    seq_in = SL'(123);
    drive_pixel(100, 50, 100, 50, 1'b1);
    tick();
    tick();
    m_seq = '0;
    m_cnt = 0;
    checks++;
    if ({in_window, seq_x_rom, seq_y_rom, seq_out, flash} !== '0)
      $display("FAIL reset_outputs: got win=%0b x=%0d y=%0d seq=%0d flash=%0b, want all 0",
               in_window, seq_x_rom, seq_y_rom, seq_out, flash);
    if ({in_window, seq_x_rom, seq_y_rom, seq_out, flash} !== '0) errors++;
    rst = 1'b0;
    frame_start = 1'b0;
    seq_in = '0;
  endtask

  task automatic test_corners();
    int px[9] = '{100, 147, 148,  99, 100, 100, 195, 196, 1023};
    int py[9] = '{ 50,  57,  57,  50,  58,  50,  65,  50,   50};
    bit vo[9] = '{  1,   1,   1,   1,   1,   0,   1,   1,    1};
    int ox[9] = '{100, 100, 100, 100, 100, 100, 100, 100, 1000};
    logic [2*SW:0] exp, got;
    for (int i = 0; i < 9; i++) begin
      drive_pixel(px[i], py[i], ox[i], 50, vo[i]);
      tick();
      tick();
      exp = pix_model(px[i], py[i], ox[i], 50, vo[i]);
      got = {in_window, seq_x_rom, seq_y_rom};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL corner_%0d (%0d,%0d vo=%0b): got win=%0b x=%0d y=%0d, want win=%0b x=%0d y=%0d",
                 i, px[i], py[i], vo[i], got[2*SW], got[2*SW-1:SW], got[SW-1:0],
                 exp[2*SW], exp[2*SW-1:SW], exp[SW-1:0]);
      end
    end
    // Window origin near the right edge must not wrap to column 0.
    drive_pixel(5, 50, 1000, 50, 1'b1);
    tick();
    tick();
    checks++;
    if (in_window !== 1'b0) begin
      errors++;
      $display("FAIL no_wrap: got win=%0b, want 0", in_window);
    end
  endtask

  task automatic test_random_window();
    logic [2*SW:0] exp, got;
    int ox, oy, px, py;
    bit vo;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 2) begin
        exp = exp_q.pop_front();
        got = {in_window, seq_x_rom, seq_y_rom};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rand_window_%0d: got win=%0b x=%0d y=%0d, want win=%0b x=%0d y=%0d",
                   i, got[2*SW], got[2*SW-1:SW], got[SW-1:0],
                   exp[2*SW], exp[2*SW-1:SW], exp[SW-1:0]);
        end
      end
      ox = int'($urandom_range(0, 1023));
      oy = int'($urandom_range(0, 1023));
      px = (ox + int'($urandom_range(0, 60 * SC)) - 6 + 1024) % 1024;
      py = (oy + int'($urandom_range(0, 12 * SC)) - 2 + 1024) % 1024;
      vo = ($urandom_range(0, 7) != 0);
      drive_pixel(px, py, ox, oy, vo);
      exp_q.push_back(pix_model(px, py, ox, oy, vo));
      tick();
    end
    video_on = 1'b0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {in_window, seq_x_rom, seq_y_rom};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_window_drain: got %0h, want %0h", got, exp);
      end
      tick();
    end
  endtask

  task automatic test_snapshot();
    seq_in = SL'(5);
    pulse_frame();
    checks++;
    if (seq_out !== SL'(5)) begin
      errors++;
      $display("FAIL snap_load5: got seq_out=%0d, want 5", seq_out);
    end
    // Mid-frame change must not reach seq_out.
    seq_in = SL'(12);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (seq_out !== SL'(5)) begin
        errors++;
        $display("FAIL snap_hold: got seq_out=%0d, want 5", seq_out);
      end
    end
    pulse_frame();
    checks++;
    if (seq_out !== SL'(12) || flash !== 1'b1) begin
      errors++;
      $display("FAIL snap_load12: got seq_out=%0d flash=%0b, want 12 / 1", seq_out, flash);
    end
    for (int i = 0; i < 3; i++) pulse_frame();
    checks++;
    if (flash !== 1'b0) begin
      errors++;
      $display("FAIL flash_cnt27: got flash=%0b, want 0", flash);
    end
    for (int i = 3; i < FLASH_N; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      pulse_frame();
      checks++;
      if (flash !== flash_model(m_cnt)) begin
        errors++;
        $display("FAIL flash_decay_%0d: got flash=%0b, want %0b", i, flash, flash_model(m_cnt));
      end
    end
    // Counter has expired: further unchanged frames keep flash low.
    pulse_frame();
    checks++;
    if (flash !== 1'b0 || m_cnt != 0) begin
      errors++;
      $display("FAIL flash_expired: got flash=%0b, want 0", flash);
    end
  endtask

  task automatic test_reload();
    seq_in = SL'(77);
    pulse_frame();
    for (int i = 0; i < 20; i++) begin
      pulse_frame();
      checks++;
      if (flash !== flash_model(m_cnt)) begin
        errors++;
        $display("FAIL reload_decay_%0d: got flash=%0b, want %0b", i, flash, flash_model(m_cnt));
      end
    end
    // Counter is now 10 (flash low); a change must reload to full.
    seq_in = SL'(78);
    pulse_frame();
    checks++;
    if (flash !== 1'b1 || seq_out !== SL'(78)) begin
      errors++;
      $display("FAIL reload_full: got flash=%0b seq_out=%0d, want 1 / 78", flash, seq_out);
    end
    pulse_frame();
    checks++;
    if (flash !== flash_model(m_cnt)) begin
      errors++;
      $display("FAIL reload_dec: got flash=%0b, want %0b", flash, flash_model(m_cnt));
    end
    for (int i = 0; i < 9; i++) pulse_frame();
  endtask

  task automatic test_reset_midstream();
    drive_pixel(100, 50, 100, 50, 1'b1);
    tick();
    tick();
    checks++;
    if (in_window !== 1'b1 || flash !== flash_model(m_cnt)) begin
      errors++;
      $display("FAIL pre_reset: got win=%0b flash=%0b, want 1 / %0b",
               in_window, flash, flash_model(m_cnt));
    end
    rst = 1'b1;
    frame_start = 1'b1;
    seq_in = SL'(999);
    tick();
    m_seq = '0;
    m_cnt = 0;
    checks++;
    if ({in_window, seq_x_rom, seq_y_rom, seq_out, flash} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got win=%0b x=%0d y=%0d seq=%0d flash=%0b, want all 0",
               in_window, seq_x_rom, seq_y_rom, seq_out, flash);
    end
    rst = 1'b0;
    frame_start = 1'b0;
    tick();
    checks++;
    if ({in_window, seq_x_rom, seq_y_rom} !== '0) begin
      errors++;
      $display("FAIL reset_pipe_empty: got win=%0b x=%0d y=%0d, want 0",
               in_window, seq_x_rom, seq_y_rom);
    end
    tick();
    checks++;
    if ({in_window, seq_x_rom, seq_y_rom} !== pix_model(100, 50, 100, 50, 1'b1) ||
        seq_out !== '0 || flash !== 1'b0) begin
      errors++;
      $display("FAIL reset_refill: got win=%0b x=%0d y=%0d seq=%0d flash=%0b, want 1/%0d/7/0/0",
               in_window, seq_x_rom, seq_y_rom, seq_out, flash, DIGITS * 8 - 1);
    end
  endtask

  task automatic test_random_frames();
    logic [SL-1:0] pool[3];
    bit fs;
    pool[0] = SL'($urandom);
    pool[1] = SL'($urandom);
    pool[2] = SL'(0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) seq_in = pool[$urandom_range(0, 2)];
      fs = ($urandom_range(0, 3) == 0);
      if (fs) begin
        pulse_frame();
      end else begin
        tick();
      end
      checks++;
      if (seq_out !== m_seq || flash !== flash_model(m_cnt)) begin
        errors++;
        $display("FAIL rand_frame_%0d: got seq_out=%0h flash=%0b, want %0h / %0b",
                 i, seq_out, flash, m_seq, flash_model(m_cnt));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    seq_in = '0;
    drive_pixel(0, 0, 0, 0, 1'b0);
    test_reset();
    test_corners();
    test_random_window();
    test_snapshot();
    test_reload();
    test_reset_midstream();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
